// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: turns the memory-access stage's combinational load/store
// request into a valid/ready data-bus transaction and stalls the pipeline
// while it is in flight. The full read word goes back to the stage.
// Optional feature macro: MEM_BRIDGE_TIMEOUT_EN (bounded wait, bus_error pulse).
module mem_bus_bridge #(
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned WordSize      = 4,
   parameter int unsigned TimeoutCycles = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 memory_read_enable,
   input  logic                 memory_write_enable,
   input  logic [AddrWidth-1:0] address,
   input  logic [DataWidth-1:0] write_data,
   input  logic [WordSize-1:0]  write_strobe,
   output logic [DataWidth-1:0] read_data,
   output logic                 stall,
   output logic                 bus_valid,
   input  logic                 bus_ready,
   output logic                 bus_write,
   output logic [AddrWidth-1:0] bus_address,
   output logic [DataWidth-1:0] bus_write_data,
   output logic [WordSize-1:0]  bus_write_strobe,
   input  logic                 bus_read_valid,
   input  logic [DataWidth-1:0] bus_read_data,
   output logic                 bus_error
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [DataWidth-1:0] wdata_q, wdata_d;
   logic [WordSize-1:0]  wstrb_q, wstrb_d;
   logic                 write_q, write_d;
   logic [DataWidth-1:0] rdata_q, rdata_d;
   logic [AddrWidth-1:0] word_addr;

   // the bus only ever sees word-aligned addresses; lane selection is in the strobe
   assign word_addr = {address[AddrWidth-1:2], 2'b00};

   logic unused_addr_bits;
   assign unused_addr_bits = ^address[1:0];

`ifdef MEM_BRIDGE_TIMEOUT_EN
   localparam int unsigned CntW = ($clog2(TimeoutCycles + 1) > 8) ?
                                  $clog2(TimeoutCycles + 1) : 8;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            timeout;

   // timeout fires on the last permitted REQ/WAIT cycle, so the bridge spends
   // exactly TimeoutCycles cycles waiting before DONE
   assign timeout = (cnt_q == CntW'(TimeoutCycles - 1));
`else
   logic [31:0] unused_timeout_cycles;
   assign unused_timeout_cycles = 32'(TimeoutCycles);
`endif

   // next-state and captured-field logic
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      write_d = write_q;
      rdata_d = rdata_q;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
`ifdef MEM_BRIDGE_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (memory_read_enable) begin
               addr_d  = word_addr;
               write_d = 1'b0;
               state_d = REQ;
            end else if (memory_write_enable) begin
               if (|write_strobe) begin
                  addr_d  = word_addr;
                  wdata_d = write_data;
                  wstrb_d = write_strobe;
                  write_d = 1'b1;
                  state_d = REQ;
               end else begin
                  state_d = DONE;
               end
            end
         end
         REQ: begin
            if (bus_ready) begin
               state_d = write_q ? DONE : WAIT;
            end
`ifdef MEM_BRIDGE_TIMEOUT_EN
            // acceptance wins over a timeout landing in the same cycle
            if (!bus_ready) begin
               if (timeout) begin
                  state_d = DONE;
                  err_d   = 1'b1;
                  if (!write_q) rdata_d = DataWidth'(32'hDEADBEEF);
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         WAIT: begin
            if (bus_read_valid) begin
               rdata_d = bus_read_data;
               state_d = DONE;
            end
`ifdef MEM_BRIDGE_TIMEOUT_EN
            else if (timeout) begin
               rdata_d = DataWidth'(32'hDEADBEEF);
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and captured-field registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         write_q <= write_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef MEM_BRIDGE_TIMEOUT_EN
   // wait-cycle counter and error pulse register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign bus_error = err_q;
`else
   assign bus_error = 1'b0;
`endif

   assign bus_valid        = (state_q == REQ);
   assign bus_write        = write_q;
   assign bus_address      = addr_q;
   assign bus_write_data   = wdata_q;
   assign bus_write_strobe = wstrb_q;
   assign read_data        = rdata_q;
   assign stall = ((state_q == IDLE) && (memory_read_enable || memory_write_enable)) ||
                  (state_q == REQ) || (state_q == WAIT);

endmodule
